// File: rtl/alg_pulse_gen.sv
// Programmable pulse-train generator: optional start delay, then N pulses of
// configurable high/low width, timed by one shared down-counter.
module alg_pulse_gen #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] delay_cyc_i,
  input  logic [CNT_W-1:0] high_cyc_i,
  input  logic [CNT_W-1:0] low_cyc_i,
  input  logic [NUM_W-1:0] pulse_num_i,
  output logic             sig_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [NUM_W-1:0] pulse_cnt_o
);

  typedef enum logic [1:0] {IDLE, DELAY, HIGH, LOW} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] lo_q, lo_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [NUM_W-1:0] pcnt_q, pcnt_d;
  logic             sig_q, sig_d;
  logic             done_q, done_d;

  // Widths are stored as reload values (width-1); a zero width behaves as 1.
  function automatic logic [CNT_W-1:0] reload(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    num_d   = num_q;
    pcnt_d  = pcnt_q;
    sig_d   = sig_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          hi_d   = reload(high_cyc_i);
          lo_d   = reload(low_cyc_i);
          num_d  = pulse_num_i;
          pcnt_d = '0;
          if (pulse_num_i == '0) begin
            done_d = 1'b1;
          end else if (delay_cyc_i == '0) begin
            state_d = HIGH;
            sig_d   = 1'b1;
            pcnt_d  = NUM_W'(1);
            cnt_d   = reload(high_cyc_i);
          end else begin
            state_d = DELAY;
            cnt_d   = delay_cyc_i - CNT_W'(1);
          end
        end
      end
      DELAY, LOW: begin
        if (cnt_q == '0) begin
          state_d = HIGH;
          sig_d   = 1'b1;
          pcnt_d  = pcnt_q + NUM_W'(1);
          cnt_d   = hi_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HIGH: begin
        if (cnt_q == '0) begin
          sig_d = 1'b0;
          // Last pulse ends the train directly; there is no trailing low phase.
          if (pcnt_q == num_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = LOW;
            cnt_d   = lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_i && state_q != IDLE) begin
      state_d = IDLE;
      sig_d   = 1'b0;
      done_d  = 1'b0;
      pcnt_d  = pcnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      num_q   <= '0;
      pcnt_q  <= '0;
      sig_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      num_q   <= num_d;
      pcnt_q  <= pcnt_d;
      sig_q   <= sig_d;
      done_q  <= done_d;
    end
  end

  assign sig_o       = sig_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign pulse_cnt_o = pcnt_q;

endmodule

// File: tb/tb_alg_pulse_gen.sv
// Directed table-driven bench for alg_pulse_gen; edge offsets are relative to
// the clock edge that samples start.
module tb_alg_pulse_gen;
  localparam int CNT_W = 16;
  localparam int NUM_W = 8;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             start_i = 1'b0;
  logic             abort_i = 1'b0;
  logic [CNT_W-1:0] delay_cyc_i = '0;
  logic [CNT_W-1:0] high_cyc_i = '0;
  logic [CNT_W-1:0] low_cyc_i = '0;
  logic [NUM_W-1:0] pulse_num_i = '0;
  logic             sig_o, busy_o, done_o;
  logic [NUM_W-1:0] pulse_cnt_o;

  alg_pulse_gen #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .delay_cyc_i(delay_cyc_i), .high_cyc_i(high_cyc_i), .low_cyc_i(low_cyc_i),
    .pulse_num_i(pulse_num_i), .sig_o(sig_o), .busy_o(busy_o), .done_o(done_o),
    .pulse_cnt_o(pulse_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int d, h, l, n;
    int len, abort_j, restart_j, rst_j;
    int fr, lf, df, dl, dn, bn, rises, pc;
  } vec_t;

  typedef struct {
    int fr, lf, df, dl, dn, bn, rises, falls, pc, ov;
  } res_t;

  int   n_chk = 0;
  int   n_fail = 0;
  logic hist_sig [64];
  logic hist_done[64];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_cfg(input vec_t v);
    delay_cyc_i = CNT_W'(v.d);
    high_cyc_i  = CNT_W'(v.h);
    low_cyc_i   = CNT_W'(v.l);
    pulse_num_i = NUM_W'(v.n);
  endtask

  task automatic scramble();
    delay_cyc_i = CNT_W'($urandom);
    high_cyc_i  = CNT_W'($urandom);
    low_cyc_i   = CNT_W'($urandom);
    pulse_num_i = NUM_W'($urandom);
  endtask

  // Launch a train at edge 0 and observe it for v.len edges like a downstream
  // edge detector would; abort/restart/reset are injected at the given edges.
  task automatic run(input vec_t v, output res_t r);
    logic prev;
    r = '{-1, -1, -1, -1, 0, 0, 0, 0, 0, 0};
    apply_cfg(v);
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    scramble();
    prev = 1'b0;
    for (int j = 0; j < v.len; j++) begin
      if (sig_o && !prev) begin
        r.rises++;
        if (r.fr < 0) r.fr = j;
      end
      if (!sig_o && prev) begin
        r.falls++;
        r.lf = j;
      end
      prev = sig_o;
      if (busy_o) r.bn++;
      if (done_o) begin
        r.dn++;
        if (r.df < 0) r.df = j;
        r.dl = j;
      end
      if (done_o && busy_o) r.ov++;
      if (j < 64) begin
        hist_sig[j]  = sig_o;
        hist_done[j] = done_o;
      end
      r.pc = int'(pulse_cnt_o);
      abort_i = (j + 1 == v.abort_j);
      rst_i   = (j + 1 == v.rst_j);
      if (j + 1 == v.restart_j) begin
        apply_cfg(v);
        start_i = 1'b1;
      end else begin
        start_i = 1'b0;
        scramble();
      end
      @(posedge clk_i); #1;
    end
    abort_i = 1'b0;
    rst_i   = 1'b0;
    start_i = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL timeout: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[12];
    res_t r;
    //          d  h      l  n    len    ab  rs  rst  fr  lf     df     dl     dn bn     rises pc
    vecs[0]  = '{3, 2,     4, 3,   25,    -1, -1, -1,  3,  17,    17,    17,    1, 17,    3,    3};
    vecs[1]  = '{0, 0,     0, 2,   8,     -1, -1, -1,  0,  3,     3,     3,     1, 3,     2,    2};
    vecs[2]  = '{5, 5,     5, 0,   6,     -1, -1, -1,  -1, -1,    0,     0,     1, 0,     0,    0};
    vecs[3]  = '{1, 1,     1, 1,   6,     -1, -1, -1,  1,  2,     2,     2,     1, 2,     1,    1};
    vecs[4]  = '{2, 3,     0, 4,   22,    -1, -1, -1,  2,  17,    17,    17,    1, 17,    4,    4};
    vecs[5]  = '{0, 5,     2, 1,   8,     -1, -1, -1,  0,  5,     5,     5,     1, 5,     1,    1};
    vecs[6]  = '{0, 1,     1, 255, 515,   -1, -1, -1,  0,  509,   509,   509,   1, 509,   255,  255};
    vecs[7]  = '{0, 65535, 7, 1,   65540, -1, -1, -1,  0,  65535, 65535, 65535, 1, 65535, 1,    1};
    vecs[8]  = '{3, 2,     4, 3,   25,    11, -1, -1,  3,  11,    -1,    -1,    0, 11,    2,    2};
    vecs[9]  = '{3, 2,     4, 3,   25,    -1, 5,  -1,  3,  17,    17,    17,    1, 17,    3,    3};
    vecs[10] = '{3, 2,     4, 3,   40,    -1, 18, -1,  3,  35,    17,    35,    2, 34,    6,    3};
    vecs[11] = '{3, 2,     4, 3,   20,    -1, -1, 4,   3,  4,     -1,    -1,    0, 4,     1,    0};

    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset sig", int'(sig_o), 0);
    check("reset busy", int'(busy_o), 0);
    check("reset done", int'(done_o), 0);
    check("reset pulse_cnt", int'(pulse_cnt_o), 0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    for (int i = 0; i < 12; i++) begin
      run(vecs[i], r);
      check($sformatf("v%0d first rise", i), r.fr, vecs[i].fr);
      check($sformatf("v%0d last fall", i), r.lf, vecs[i].lf);
      check($sformatf("v%0d first done", i), r.df, vecs[i].df);
      check($sformatf("v%0d last done", i), r.dl, vecs[i].dl);
      check($sformatf("v%0d done count", i), r.dn, vecs[i].dn);
      check($sformatf("v%0d busy cycles", i), r.bn, vecs[i].bn);
      check($sformatf("v%0d rises", i), r.rises, vecs[i].rises);
      check($sformatf("v%0d falls", i), r.falls, vecs[i].rises);
      check($sformatf("v%0d pulse_cnt", i), r.pc, vecs[i].pc);
      check($sformatf("v%0d done&busy", i), r.ov, 0);
      if (i == 1) begin
        check("zero-width sig@0", int'(hist_sig[0]), 1);
        check("zero-width sig@1", int'(hist_sig[1]), 0);
        check("zero-width sig@2", int'(hist_sig[2]), 1);
        check("zero-width sig@3", int'(hist_sig[3]), 0);
        check("zero-width done@2", int'(hist_done[2]), 0);
        check("zero-width done@3", int'(hist_done[3]), 1);
      end
    end

    // start together with abort while idle must be dropped
    delay_cyc_i = '0;
    high_cyc_i  = 16'd2;
    low_cyc_i   = 16'd2;
    pulse_num_i = 8'd2;
    start_i = 1'b1;
    abort_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    abort_i = 1'b0;
    check("start+abort busy", int'(busy_o), 0);
    check("start+abort sig", int'(sig_o), 0);
    check("start+abort done", int'(done_o), 0);
    @(posedge clk_i); #1;
    check("start+abort busy later", int'(busy_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
